// File: rtl/instr_encoder.sv
// Packs instruction fields into a 32-bit word and buffers it in a small valid/ready FIFO.
// Optional macro INSTR_COUNT_EN adds a 16-bit running count of accepted pushes (enc_count).
module instr_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         bc,
    input  logic               ct,
    input  logic [4:0]         opcode,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [13:0]        immediate,
    input  logic [18:0]        jump_immediate,
    input  logic [23:0]        system_op,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
`ifdef INSTR_COUNT_EN
    output logic [15:0]        enc_count,
`endif
    output logic [PTR_W:0]     count
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [31:0]      packed_word;
    logic             push;
    logic             pop;

    // Field packing; fields outside the selected format never reach the word.
    always_comb begin
        packed_word        = '0;
        packed_word[31:30] = bc;
        packed_word[29]    = ct;
        packed_word[28:24] = opcode;
        case (bc)
            2'b00: begin
                packed_word[23:19] = rd;
                packed_word[18:14] = rs1;
                packed_word[13:9]  = rs2;
            end
            2'b01: begin
                packed_word[23:19] = rd;
                packed_word[18:14] = rs1;
                packed_word[13:0]  = immediate;
            end
            2'b10: begin
                packed_word[23:19] = rd;
                packed_word[18:0]  = jump_immediate;
            end
            default: packed_word[23:0] = system_op;
        endcase
    end

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign out_instr = mem[rd_ptr];
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= packed_word;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef INSTR_COUNT_EN
    // Lifetime push counter; survives flush, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
        end else if (push) begin
            enc_count <= enc_count + 16'd1;
        end
    end
`endif

endmodule
